// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED driver (led_blink_ctrl).
// The LED_BREATHE_EN macro selects mode 3 behaviour: breathing when defined, static PWM otherwise.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  // Channel-index width. It never drops below one bit, so a single-channel build still has a port.
  function automatic int ch_width(input int num_led);
    return (num_led > 1) ? $clog2(num_led) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode, blink phase and PWM duty, and drives a registered LED bit.
// With LED_BREATHE_EN defined, mode 3 ramps the duty up and down on each tick; otherwise it uses the loaded duty.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [PWM_W-1:0]  pwm_cnt,
  input  logic              load,
  input  logic [MODE_W-1:0] mode,
  input  logic [PWM_W-1:0]  duty,
  output logic              led
);

  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [PWM_W-1:0] DUTY_ONE = PWM_W'(1);

  led_mode_e        mode_q;
  logic             phase_q;
  logic [PWM_W-1:0] duty_q;
`ifdef LED_BREATHE_EN
  breathe_dir_e     dir_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= LED_OFF;
      phase_q <= 1'b0;
      duty_q  <= '0;
`ifdef LED_BREATHE_EN
      dir_q   <= DIR_UP;
`endif
      led     <= 1'b0;
    end else begin
      // A load takes priority over a coincident tick, so the pattern restarts cleanly.
      if (load) begin
        mode_q  <= led_mode_e'(mode);
        phase_q <= 1'b0;
`ifdef LED_BREATHE_EN
        duty_q  <= '0;
        dir_q   <= DIR_UP;
`else
        duty_q  <= duty;
`endif
      end else if (tick) begin
        if (mode_q == LED_BLINK) begin
          phase_q <= ~phase_q;
        end
`ifdef LED_BREATHE_EN
        if (mode_q == LED_BREATHE) begin
          if (dir_q == DIR_UP) begin
            if (duty_q == DUTY_MAX) begin
              dir_q  <= DIR_DOWN;
              duty_q <= DUTY_MAX - DUTY_ONE;
            end else begin
              duty_q <= duty_q + DUTY_ONE;
            end
          end else begin
            if (duty_q == '0) begin
              dir_q  <= DIR_UP;
              duty_q <= DUTY_ONE;
            end else begin
              duty_q <= duty_q - DUTY_ONE;
            end
          end
        end
`endif
      end

      // NOTE: the LED is computed from the state before this edge, so a new mode shows on the following clock.
      case (mode_q)
        LED_OFF:   led <= 1'b0;
        LED_ON:    led <= 1'b1;
        LED_BLINK: led <= phase_q;
        default:   led <= (pwm_cnt < duty_q);
      endcase
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver with a shared prescaler tick, a shared PWM counter and per-channel configuration.
// Define LED_BREATHE_EN to make mode 3 breathe; otherwise mode 3 is static PWM at cfg_duty.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LED    = 4,
  parameter int PRESCALE_W = 16,
  parameter int PWM_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ch_width(NUM_LED)-1:0] cfg_ch,
  input  logic [MODE_W-1:0]            cfg_mode,
  input  logic [PWM_W-1:0]             cfg_duty,
  output logic                         tick,
  output logic [NUM_LED-1:0]           led
);

  localparam int CH_W = ch_width(NUM_LED);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);
  localparam logic [PWM_W-1:0]      PWM_ONE = PWM_W'(1);

  logic [PRESCALE_W-1:0] prescaler;
  logic [PWM_W-1:0]      pwm_cnt;
  logic                  accept;

  // NOTE: every register here sits under the synchronous reset; there is no memory array to leave uninitialised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      tick      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      prescaler <= prescaler + PRE_ONE;
      pwm_cnt   <= pwm_cnt + PWM_ONE;
      tick      <= &prescaler;
      cfg_ready <= 1'b1;
    end
  end

  assign accept = cfg_valid & cfg_ready;

  // An out-of-range channel index matches no instance, so the transfer completes without changing any state.
  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    led_channel #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .load    (accept && (cfg_ch == CH_W'(i))),
      .mode    (cfg_mode),
      .duty    (cfg_duty),
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl (PRESCALE_W=4, PWM_W=3); a 3-channel copy exercises an out-of-range cfg_ch.
// Mode 3 expectations follow LED_BREATHE_EN.
module tb_led_blink_ctrl;
  import led_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_ch_s;
  logic [1:0] cfg_mode;
  logic [2:0] cfg_duty;
  logic       cfg_ready, cfg_ready_s;
  logic       tick, tick_s;
  logic [3:0] led;
  logic [2:0] led_s;

  int cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  led_blink_ctrl #(.NUM_LED(4), .PRESCALE_W(4), .PWM_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .tick(tick), .led(led)
  );

  led_blink_ctrl #(.NUM_LED(3), .PRESCALE_W(4), .PWM_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s),
    .cfg_ch(cfg_ch_s), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .tick(tick_s), .led(led_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of clock edges since reset was released.
  always @(posedge clk) cnt <= rst_n ? cnt + 1 : 0;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cnt=%0d)", cnt);
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cnt=%0d)", tag, got, exp, cnt);
  endtask

  // Called at a falling edge; the transfer is accepted at the next rising edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] ch_s,
                           input logic [1:0] mode, input logic [2:0] duty);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_ch_s  = ch_s;
    cfg_mode  = mode;
    cfg_duty  = duty;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  int tbl [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    logic [3:0] e;
    int hi;
    int hi2;
    int k;
    int d;

    rst_n = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_ch_s = 2'd0;
    cfg_mode = LED_ON; cfg_duty = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_ready", int'(cfg_ready), 0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(cfg_ready), 1);
    check("ready_after_release_s", int'(cfg_ready_s), 1);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("no_accept_in_reset", int'(led), 0);

    // Tick is high exactly when 16, 32, 48... edges have elapsed.
    while (cnt < 64) begin
      check("tick_period", int'(tick), int'(cnt % 16 == 0));
      @(negedge clk);
    end
    check("tick_64", int'(tick), 1);
    check("tick_64_s", int'(tick_s), 1);

    // ON to ch2: accepted at edge 65, visible from edge 66.
    cfg_write(2'd2, 2'd2, LED_ON, 3'd0);
    check("on_edge_k", int'(led), 0);
    @(negedge clk);
    check("on_edge_k1", int'(led), 4);
    check("on_edge_k1_s", int'(led_s), 4);

    // Out-of-range channel 3 on the 3-channel copy changes nothing.
    cfg_write(2'd2, 2'd3, LED_ON, 3'd0);
    @(negedge clk);
    check("oor_main", int'(led), 4);
    check("oor_small", int'(led_s), 4);

    // BLINK ch1 accepted at edge 69; phase toggles at edges 81 and 97.
    cfg_write(2'd1, 2'd1, LED_BLINK, 3'd0);
    while (cnt < 110) begin
      e = {1'b0, 1'b1, (cnt >= 82 && cnt < 98), 1'b0};
      check("blink_ch1", int'(led), int'(e));
      @(negedge clk);
    end

    // Mode 3 on ch0 accepted at edge 111.
    cfg_write(2'd0, 2'd0, LED_BREATHE, 3'd3);
`ifdef LED_BREATHE_EN
    hi = 0;
    while (cnt < 352) begin
      @(negedge clk);
      k = (cnt - 1 < 113) ? 0 : (cnt - 1 - 113) / 16 + 1;
      d = (k == 0) ? 0 : tbl[k - 1];
      check("breathe_led", int'(led[0]), int'(((cnt - 1) % 8) < d));
      if ((cnt - 1) % 16 == 8) hi = 0;
      hi += int'(led[0]);
      if ((cnt - 1) % 16 == 15 && cnt - 1 >= 127)
        check("breathe_window", hi, tbl[(cnt - 1 - 127) / 16]);
    end
`else
    hi = 0;
    hi2 = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("pwm_led", int'(led[0]), int'(((cnt - 1) % 8) < 3));
      if (i < 8) hi += int'(led[0]);
      else hi2 += int'(led[0]);
    end
    check("pwm_window_a", hi, 3);
    check("pwm_window_b", hi2, 3);
`endif

    // Reconfigure ch1 on the cycle tick is high: phase restarts and that tick is ignored.
    while (cnt % 16 != 0) @(negedge clk);
    cfg_write(2'd1, 2'd1, LED_BLINK, 3'd0);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("restart_ch1", int'(led[1]), int'(i == 17));
    end

    // Reset mid-pattern clears everything at the next edge.
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_led_s", int'(led_s), 0);
    check("mid_rst_tick", int'(tick), 0);
    check("mid_rst_ready", int'(cfg_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    while (cnt < 20) begin
      check("post_rst_led", int'(led), 0);
      check("post_rst_tick", int'(tick), int'(cnt == 16));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
